// File: rtl/seq_stage_controller_pkg.sv
// Shared Y86-64 SEQ sequencer definitions: controller states, icode and status encodings.
package seq_stage_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_PC_UPDATE,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  // Instructions that touch data memory in the MEMORY stage.
  function automatic logic is_mem_icode(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) ||
           (ic == IRET) || (ic == IPUSHQ) || (ic == IPOPQ);
  endfunction

endpackage

// File: rtl/seq_stage_controller_mem_wait_timer.sv
// Down-counting wait timer for memory handshakes; pulses timeout on the last allowed cycle
// when ready has still not arrived.
module seq_stage_controller_mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] remaining;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      remaining <= LOAD;
    end else if (enable && !ready && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

  // A ready in the terminal cycle suppresses the fault.
  assign timeout = enable && !ready && (remaining == '0);

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle Y86-64 SEQ sequencer: owns the PC, steps the stages one instruction at a time,
// handshakes with instruction/data memory and stops on any non-AOK status.
//
// state        | meaning
// ST_IDLE      | waiting for run
// ST_FETCH     | imem request outstanding, latch icode on ready
// ST_DECODE    | decode strobe, one cycle
// ST_EXECUTE   | execute strobe, cc write for OPq
// ST_MEMORY    | data access for memory icodes, else one cycle
// ST_WRITEBACK | writeback strobe, one cycle
// ST_PC_UPDATE | commit PC_new, retire instruction
// ST_HALT      | stopped on non-AOK status until reset
module seq_stage_controller
  import seq_stage_controller_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [3:0]           icode,
  input  logic                 instr_valid,
  input  logic                 imem_ready,
  input  logic                 imem_error,
  input  logic                 dmem_ready,
  input  logic                 dmem_error,
  input  logic [63:0]          PC_new,
  output logic [63:0]          pc,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 fetch_en,
  output logic                 decode_en,
  output logic                 execute_en,
  output logic                 memory_en,
  output logic                 writeback_en,
  output logic                 cc_we,
  output logic [2:0]           stat,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_e     state, state_nxt;
  stat_e      stat_q, stat_nxt;
  logic [3:0] icode_q;
  logic       mem_access;
  logic       wait_en;
  logic       wait_timeout;

  assign mem_access = is_mem_icode(icode_q);
  assign wait_en    = (state == ST_FETCH) || ((state == ST_MEMORY) && mem_access);
  assign stat       = stat_q;

  seq_stage_controller_mem_wait_timer #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!wait_en),
    .enable (wait_en),
    .ready  ((state == ST_FETCH) ? imem_ready : dmem_ready),
    .timeout(wait_timeout)
  );

  always_comb begin
    state_nxt = state;
    stat_nxt  = stat_q;
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          if (imem_error) begin
            stat_nxt  = SADR;
            state_nxt = ST_HALT;
          end else if (!instr_valid) begin
            stat_nxt  = SINS;
            state_nxt = ST_HALT;
          end else if (icode == IHALT) begin
            stat_nxt  = SHLT;
            state_nxt = ST_HALT;
          end else begin
            state_nxt = ST_DECODE;
          end
        end else if (wait_timeout) begin
          stat_nxt  = SADR;
          state_nxt = ST_HALT;
        end
      end
      ST_DECODE:  state_nxt = ST_EXECUTE;
      ST_EXECUTE: state_nxt = ST_MEMORY;
      ST_MEMORY: begin
        if (!mem_access) begin
          state_nxt = ST_WRITEBACK;
        end else if (dmem_ready) begin
          if (dmem_error) begin
            stat_nxt  = SADR;
            state_nxt = ST_HALT;
          end else begin
            state_nxt = ST_WRITEBACK;
          end
        end else if (wait_timeout) begin
          stat_nxt  = SADR;
          state_nxt = ST_HALT;
        end
      end
      ST_WRITEBACK: state_nxt = ST_PC_UPDATE;
      ST_PC_UPDATE: state_nxt = run ? ST_FETCH : ST_IDLE;
      ST_HALT:      state_nxt = ST_HALT;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      stat_q       <= SAOK;
      pc           <= RESET_PC;
      icode_q      <= '0;
      cycle_count  <= '0;
      instr_count  <= '0;
      imem_req     <= 1'b0;
      dmem_req     <= 1'b0;
      fetch_en     <= 1'b0;
      decode_en    <= 1'b0;
      execute_en   <= 1'b0;
      memory_en    <= 1'b0;
      writeback_en <= 1'b0;
      cc_we        <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state  <= state_nxt;
      stat_q <= stat_nxt;
      if ((state == ST_FETCH) && imem_ready) icode_q <= icode;
      if (state == ST_PC_UPDATE) begin
        pc          <= PC_new;
        instr_count <= instr_count + 1'b1;
      end
      if ((state != ST_IDLE) && (state != ST_HALT)) cycle_count <= cycle_count + 1'b1;
      imem_req     <= (state_nxt == ST_FETCH);
      fetch_en     <= (state_nxt == ST_FETCH);
      decode_en    <= (state_nxt == ST_DECODE);
      execute_en   <= (state_nxt == ST_EXECUTE);
      memory_en    <= (state_nxt == ST_MEMORY);
      writeback_en <= (state_nxt == ST_WRITEBACK);
      dmem_req     <= (state_nxt == ST_MEMORY) && mem_access;
      cc_we        <= (state_nxt == ST_EXECUTE) && (icode_q == IOPQ);
      halted       <= (state_nxt == ST_HALT);
    end
  end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Bench for seq_stage_controller: directed scenarios plus random programs checked
// against an instruction-level timing/status model.
module tb_seq_stage_controller;

  localparam int T = 16;

  typedef struct {
    logic [3:0]  icode;
    bit          valid;
    int          iw;
    bit          ierr;
    int          dw;
    bit          derr;
    logic [63:0] pc_new;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  icode = '0;
  logic        instr_valid = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_error = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        dmem_error = 1'b0;
  logic [63:0] PC_new = '0;
  logic [63:0] pc;
  logic        imem_req, dmem_req, fetch_en, decode_en, execute_en, memory_en, writeback_en;
  logic        cc_we, halted;
  logic [2:0]  stat;
  logic [31:0] cycle_count, instr_count;

  int n_tests = 0;
  int n_fail = 0;

  instr_t prog[$];
  int idx, fc, dc;
  bit prev_f, prev_d;
  int cnt_fetch, cnt_dec, cnt_wb, cnt_dm, cnt_cc;

  seq_stage_controller #(.RESET_PC(64'h0), .MEM_TIMEOUT(T), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .run(run), .icode(icode), .instr_valid(instr_valid),
    .imem_ready(imem_ready), .imem_error(imem_error), .dmem_ready(dmem_ready),
    .dmem_error(dmem_error), .PC_new(PC_new), .pc(pc), .imem_req(imem_req),
    .dmem_req(dmem_req), .fetch_en(fetch_en), .decode_en(decode_en),
    .execute_en(execute_en), .memory_en(memory_en), .writeback_en(writeback_en),
    .cc_we(cc_we), .stat(stat), .halted(halted), .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Memory responder: answers requests after each instruction's programmed wait.
  always @(negedge clk) begin
    instr_t cur;
    if (reset) begin
      idx = -1; fc = 0; dc = 0; prev_f = 0; prev_d = 0;
      cnt_fetch = 0; cnt_dec = 0; cnt_wb = 0; cnt_dm = 0; cnt_cc = 0;
      imem_ready = 0; dmem_ready = 0; imem_error = 0; dmem_error = 0;
    end else begin
      cnt_fetch += int'(fetch_en);
      cnt_dec   += int'(decode_en);
      cnt_wb    += int'(writeback_en);
      cnt_dm    += int'(dmem_req);
      cnt_cc    += int'(cc_we);
      if (fetch_en) begin
        if (!prev_f) begin idx++; fc = 0; end
        else fc++;
      end
      if (dmem_req) begin
        if (!prev_d) dc = 0;
        else dc++;
      end
      prev_f = fetch_en;
      prev_d = dmem_req;
      if (idx >= 0 && idx < prog.size()) cur = prog[idx];
      else begin
        cur.icode = 4'h0; cur.valid = 1; cur.iw = 0; cur.ierr = 0;
        cur.dw = 0; cur.derr = 0; cur.pc_new = '0;
      end
      imem_ready  = fetch_en && (fc == cur.iw);
      imem_error  = imem_ready ? cur.ierr : 1'($urandom_range(0, 1));
      instr_valid = imem_ready ? cur.valid : 1'($urandom_range(0, 1));
      icode       = imem_ready ? cur.icode : 4'($urandom_range(0, 15));
      dmem_ready  = dmem_req && (dc == cur.dw);
      dmem_error  = dmem_ready ? cur.derr : 1'($urandom_range(0, 1));
      PC_new      = cur.pc_new;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic instr_t mk(logic [3:0] ic, bit v, int iw, bit ie, int dw, bit de,
                                logic [63:0] pn);
    instr_t r;
    r.icode = ic; r.valid = v; r.iw = iw; r.ierr = ie; r.dw = dw; r.derr = de; r.pc_new = pn;
    return r;
  endfunction

  // Instruction-level reference: cycles spent, final status/pc and per-stage activity.
  function automatic void model(output int cyc, output logic [2:0] st, output logic [63:0] mpc,
                                output int ic, output int dec, output int wb,
                                output int dm, output int cc);
    cyc = 0; st = 3'd1; mpc = 64'h0; ic = 0; dec = 0; wb = 0; dm = 0; cc = 0;
    for (int i = 0; i < prog.size(); i++) begin
      instr_t it = prog[i];
      bit mem = it.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      if (it.iw >= T) begin cyc += T; st = 3'd3; break; end
      cyc += it.iw + 1;
      if (it.ierr) begin st = 3'd3; break; end
      if (!it.valid) begin st = 3'd4; break; end
      if (it.icode == 4'h0) begin st = 3'd2; break; end
      dec++;
      if (it.icode == 4'h6) cc++;
      cyc += 2;
      if (mem) begin
        if (it.dw >= T) begin cyc += T; dm += T; st = 3'd3; break; end
        cyc += it.dw + 1;
        dm += it.dw + 1;
        if (it.derr) begin st = 3'd3; break; end
      end else begin
        cyc += 1;
      end
      wb++;
      cyc += 2;
      mpc = it.pc_new;
      ic++;
    end
  endfunction

  task automatic run_prog(output int cyc);
    reset = 1; run = 1;
    tick(); tick();
    reset = 0;
    cyc = 0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (halted === 1'b1) break;
      cyc++;
    end
    n_tests++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL run_timeout: halted=%b after %0d cycles, required 1", halted, cyc);
    end
  endtask

  task automatic test_reset();
    run = 0; reset = 1;
    tick(); tick();
    n_tests++;
    if ({imem_req, dmem_req, fetch_en, decode_en, execute_en, memory_en, writeback_en,
         cc_we, halted} !== 9'b0) begin
      n_fail++; $display("FAIL reset_strobes: got nonzero strobe, required all 0");
    end
    n_tests++;
    if (pc !== 64'h0 || stat !== 3'd1) begin
      n_fail++; $display("FAIL reset_pc_stat: pc=%h stat=%0d, required 0 and 1", pc, stat);
    end
    n_tests++;
    if (cycle_count !== 0 || instr_count !== 0) begin
      n_fail++; $display("FAIL reset_counts: cyc=%0d instr=%0d, required 0", cycle_count, instr_count);
    end
    reset = 0;
    tick(); tick();
    n_tests++;
    if (fetch_en !== 1'b0) begin
      n_fail++; $display("FAIL idle_without_run: fetch_en=%b, required 0", fetch_en);
    end
  endtask

  task automatic test_halt_program();
    int cyc;
    prog.delete();
    prog.push_back(mk(4'h3, 1, 0, 0, 0, 0, 64'd10));
    prog.push_back(mk(4'h0, 1, 0, 0, 0, 0, 64'd99));
    run_prog(cyc);
    n_tests++;
    if (cyc !== 7 || cycle_count !== 32'd7) begin
      n_fail++; $display("FAIL halt_prog_cycles: got %0d/%0d, required 7", cyc, cycle_count);
    end
    n_tests++;
    if (stat !== 3'd2 || pc !== 64'd10 || instr_count !== 32'd1) begin
      n_fail++; $display("FAIL halt_prog_state: stat=%0d pc=%0d instr=%0d, required 2 10 1",
                         stat, pc, instr_count);
    end
  endtask

  task automatic test_call_delay();
    int cyc;
    prog.delete();
    prog.push_back(mk(4'h8, 1, 0, 0, 3, 0, 64'h40));
    prog.push_back(mk(4'h0, 1, 0, 0, 0, 0, 64'h0));
    run_prog(cyc);
    n_tests++;
    if (cnt_dm !== 4) begin
      n_fail++; $display("FAIL call_dmem_req: got %0d cycles, required 4", cnt_dm);
    end
    n_tests++;
    if (pc !== 64'h40 || cyc !== 10 || stat !== 3'd2) begin
      n_fail++; $display("FAIL call_result: pc=%h cyc=%0d stat=%0d, required 40 10 2", pc, cyc, stat);
    end
  endtask

  task automatic test_invalid();
    int cyc;
    prog.delete();
    prog.push_back(mk(4'h3, 0, 0, 0, 0, 0, 64'h55));
    run_prog(cyc);
    n_tests++;
    if (stat !== 3'd4 || halted !== 1'b1 || pc !== 64'h0 || instr_count !== 0 || cnt_dec !== 0) begin
      n_fail++; $display("FAIL invalid_instr: stat=%0d pc=%h instr=%0d dec=%0d, required 4 0 0 0",
                         stat, pc, instr_count, cnt_dec);
    end
  endtask

  task automatic test_dmem_timeout();
    int cyc;
    prog.delete();
    prog.push_back(mk(4'h5, 1, 0, 0, 1000, 0, 64'h8));
    run_prog(cyc);
    n_tests++;
    if (stat !== 3'd3 || cnt_dm !== T || cnt_wb !== 0 || cyc !== 19) begin
      n_fail++; $display("FAIL dmem_timeout: stat=%0d dm=%0d wb=%0d cyc=%0d, required 3 16 0 19",
                         stat, cnt_dm, cnt_wb, cyc);
    end
  endtask

  task automatic test_fetch_boundary();
    int cyc;
    prog.delete();
    prog.push_back(mk(4'h1, 1, T - 1, 0, 0, 0, 64'h2));
    prog.push_back(mk(4'h0, 1, 0, 0, 0, 0, 64'h0));
    run_prog(cyc);
    n_tests++;
    if (stat !== 3'd2 || cyc !== 22 || pc !== 64'h2) begin
      n_fail++; $display("FAIL fetch_ready_at_limit: stat=%0d cyc=%0d pc=%h, required 2 22 2",
                         stat, cyc, pc);
    end
    prog.delete();
    prog.push_back(mk(4'h1, 1, T, 0, 0, 0, 64'h2));
    run_prog(cyc);
    n_tests++;
    if (stat !== 3'd3 || cyc !== T || pc !== 64'h0) begin
      n_fail++; $display("FAIL fetch_timeout: stat=%0d cyc=%0d pc=%h, required 3 16 0", stat, cyc, pc);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    prog.delete();
    prog.push_back(mk(4'h6, 1, 0, 0, 0, 0, 64'd20));
    prog.push_back(mk(4'h0, 1, 0, 0, 0, 0, 64'd0));
    reset = 1; run = 1;
    tick(); tick();
    reset = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (execute_en === 1'b1) begin seen = 1; break; end
    end
    n_tests++;
    if (!seen || cc_we !== 1'b1) begin
      n_fail++; $display("FAIL opq_execute: seen=%0d cc_we=%b, required 1 1", seen, cc_we);
    end
    reset = 1; run = 0;
    tick();
    n_tests++;
    if ({fetch_en, decode_en, execute_en, memory_en, writeback_en, cc_we, halted} !== 7'b0 ||
        pc !== 64'h0 || cycle_count !== 0 || instr_count !== 0 || stat !== 3'd1) begin
      n_fail++; $display("FAIL reset_mid: pc=%h cyc=%0d instr=%0d stat=%0d, required 0 0 0 1",
                         pc, cycle_count, instr_count, stat);
    end
    reset = 0;
    tick(); tick();
    n_tests++;
    if (fetch_en !== 1'b0 || instr_count !== 0) begin
      n_fail++; $display("FAIL reset_mid_idle: fetch_en=%b instr=%0d, required 0 0", fetch_en, instr_count);
    end
  endtask

  task automatic test_run_drop();
    bit seen = 0;
    prog.delete();
    prog.push_back(mk(4'h3, 1, 0, 0, 0, 0, 64'd10));
    prog.push_back(mk(4'h0, 1, 0, 0, 0, 0, 64'd0));
    reset = 1; run = 1;
    tick(); tick();
    reset = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (decode_en === 1'b1) begin seen = 1; break; end
    end
    run = 0;
    repeat (10) tick();
    n_tests++;
    if (!seen || instr_count !== 1 || pc !== 64'd10 || fetch_en !== 1'b0 || halted !== 1'b0 ||
        cnt_fetch !== 1) begin
      n_fail++; $display("FAIL run_drop_retire: instr=%0d pc=%0d fetch_en=%b fetches=%0d, required 1 10 0 1",
                         instr_count, pc, fetch_en, cnt_fetch);
    end
    run = 1;
    tick();
    n_tests++;
    if (fetch_en !== 1'b1) begin
      n_fail++; $display("FAIL run_resume: fetch_en=%b, required 1", fetch_en);
    end
    tick();
    n_tests++;
    if (halted !== 1'b1 || stat !== 3'd2) begin
      n_fail++; $display("FAIL run_resume_halt: halted=%b stat=%0d, required 1 2", halted, stat);
    end
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 17) return $urandom_range(1, 4);
    if (r == 17) return T - 1;
    if (r == 18) return T;
    return 40;
  endfunction

  task automatic test_random();
    int cyc, e_cyc, e_ic, e_dec, e_wb, e_dm, e_cc;
    logic [2:0] e_st;
    logic [63:0] e_pc;
    for (int p = 0; p < 40; p++) begin
      int n = $urandom_range(1, 5);
      prog.delete();
      for (int i = 0; i < n; i++)
        prog.push_back(mk(4'($urandom_range(0, 11)), ($urandom_range(0, 19) != 0), pick_wait(),
                          ($urandom_range(0, 24) == 0), pick_wait(), ($urandom_range(0, 19) == 0),
                          {$urandom, $urandom}));
      prog.push_back(mk(4'h0, 1, $urandom_range(0, 3), 0, 0, 0, 64'h0));
      model(e_cyc, e_st, e_pc, e_ic, e_dec, e_wb, e_dm, e_cc);
      run_prog(cyc);
      n_tests++;
      if (cyc !== e_cyc || cycle_count !== 32'(e_cyc)) begin
        n_fail++; $display("FAIL rnd%0d_cycles: got %0d/%0d, required %0d", p, cyc, cycle_count, e_cyc);
      end
      n_tests++;
      if (stat !== e_st) begin
        n_fail++; $display("FAIL rnd%0d_stat: got %0d, required %0d", p, stat, e_st);
      end
      n_tests++;
      if (pc !== e_pc) begin
        n_fail++; $display("FAIL rnd%0d_pc: got %h, required %h", p, pc, e_pc);
      end
      n_tests++;
      if (instr_count !== 32'(e_ic)) begin
        n_fail++; $display("FAIL rnd%0d_instr_count: got %0d, required %0d", p, instr_count, e_ic);
      end
      n_tests++;
      if (cnt_dec !== e_dec || cnt_wb !== e_wb) begin
        n_fail++; $display("FAIL rnd%0d_stages: dec=%0d wb=%0d, required %0d %0d",
                           p, cnt_dec, cnt_wb, e_dec, e_wb);
      end
      n_tests++;
      if (cnt_dm !== e_dm || cnt_cc !== e_cc) begin
        n_fail++; $display("FAIL rnd%0d_dmem_cc: dm=%0d cc=%0d, required %0d %0d",
                           p, cnt_dm, cnt_cc, e_dm, e_cc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_halt_program();
    test_call_delay();
    test_invalid();
    test_dmem_timeout();
    test_fetch_boundary();
    test_reset_mid();
    test_run_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
